// File: rtl/ascii_pkg.sv
// Shared constants and types for the ASCII decimal number decoder:
// character codes, FSM state encoding and datapath widths.
package ascii_pkg;

    localparam int VALUE_W    = 16;
    localparam int ACC_W      = 17;
    localparam int MAX_DIGITS = 5;
    localparam int DIGITS_W   = 3;

    localparam logic [7:0] CHAR_DIGIT_BASE = 8'h30;
    localparam logic [7:0] CHAR_DIGIT_LAST = 8'h39;
    localparam logic [7:0] CHAR_SPACE      = 8'h20;
    localparam logic [7:0] CHAR_COMMA      = 8'h2C;
    localparam logic [7:0] CHAR_CR         = 8'h0D;
    localparam logic [7:0] CHAR_LF         = 8'h0A;
    localparam logic [7:0] CHAR_MINUS      = 8'h2D;

    localparam logic [ACC_W-1:0] LIMIT_UNSIGNED = 17'd65535;
    localparam logic [ACC_W-1:0] LIMIT_POS      = 17'd32767;
    localparam logic [ACC_W-1:0] LIMIT_NEG      = 17'd32768;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2,
        SKIP  = 2'd3
    } state_t;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational character classifier: digit, delimiter, minus sign and the
// binary value of a digit character.
module ascii_char_class
    import ascii_pkg::*;
(
    input  logic [7:0] in_data,
    output logic       is_digit,
    output logic       is_delim,
    output logic       is_minus,
    output logic [3:0] digit_value
);

    logic [7:0] offset;

    assign offset      = in_data - CHAR_DIGIT_BASE;
    assign digit_value = offset[3:0];
    assign is_digit    = (in_data >= CHAR_DIGIT_BASE) && (in_data <= CHAR_DIGIT_LAST);
    assign is_delim    = (in_data == CHAR_SPACE) || (in_data == CHAR_COMMA) ||
                         (in_data == CHAR_CR)    || (in_data == CHAR_LF);
    assign is_minus    = (in_data == CHAR_MINUS);

endmodule

// File: rtl/ascii_num_decoder.sv
// Streaming ASCII decimal-to-binary decoder with ready/valid on both sides.
// Define ASCII_SIGN_EN to accept a leading '-' and emit two's complement values.
module ascii_num_decoder
    import ascii_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [VALUE_W-1:0]  out_value,
    output logic [DIGITS_W-1:0] out_digits,
    output logic                err
);

    logic                is_digit, is_delim, is_minus;
    logic [3:0]          digit_value;
    state_t              state, state_next;
    logic [ACC_W-1:0]    acc, acc_mac, limit;
    logic [VALUE_W-1:0]  mag;
    logic [DIGITS_W-1:0] digits;
    logic                neg, sign_char, accept;
    logic                err_next, load_digit, load_sign, step, latch_out;

    ascii_char_class u_char_class (
        .in_data     (in_data),
        .is_digit    (is_digit),
        .is_delim    (is_delim),
        .is_minus    (is_minus),
        .digit_value (digit_value)
    );

    assign accept  = in_valid && in_ready;
    assign acc_mac = acc * ACC_W'(10) + ACC_W'(digit_value);
    assign mag     = acc[VALUE_W-1:0];

`ifdef ASCII_SIGN_EN
    assign sign_char = is_minus;
    assign limit     = neg ? LIMIT_NEG : LIMIT_POS;
`else
    logic unused_minus;
    assign unused_minus = is_minus;
    assign sign_char    = 1'b0;
    assign limit        = LIMIT_UNSIGNED;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_next = state;
        err_next   = 1'b0;
        load_digit = 1'b0;
        load_sign  = 1'b0;
        step       = 1'b0;
        latch_out  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (is_digit) begin
                        load_digit = 1'b1;
                        state_next = ACCUM;
                    end else if (sign_char) begin
                        load_sign  = 1'b1;
                        state_next = ACCUM;
                    end else if (!is_delim) begin
                        err_next   = 1'b1;
                        state_next = SKIP;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (is_digit) begin
                        // The digit-count test comes first, so acc_mac is only trusted for acc <= 9999.
                        if ((digits >= DIGITS_W'(MAX_DIGITS)) || (acc_mac > limit)) begin
                            err_next   = 1'b1;
                            state_next = SKIP;
                        end else begin
                            step = 1'b1;
                        end
                    end else if (is_delim) begin
                        if (digits == '0) begin
                            err_next   = 1'b1;
                            state_next = IDLE;
                        end else begin
                            latch_out  = 1'b1;
                            state_next = HOLD;
                        end
                    end else begin
                        err_next   = 1'b1;
                        state_next = SKIP;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            SKIP: begin
                if (accept && is_delim) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state != HOLD);
        out_valid = (state == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc        <= '0;
            digits     <= '0;
            neg        <= 1'b0;
            out_value  <= '0;
            out_digits <= '0;
            err        <= 1'b0;
        end else begin
            err <= err_next;
            if (load_digit) begin
                acc    <= ACC_W'(digit_value);
                digits <= DIGITS_W'(1);
                neg    <= 1'b0;
            end else if (load_sign) begin
                acc    <= '0;
                digits <= '0;
                neg    <= 1'b1;
            end else if (step) begin
                acc    <= acc_mac;
                digits <= digits + 1'b1;
            end
            if (latch_out) begin
                out_value  <= neg ? (~mag + 1'b1) : mag;
                out_digits <= digits;
            end
        end
    end

endmodule

// File: tb/tb_ascii_num_decoder.sv
// Self-checking bench for ascii_num_decoder: directed token scenarios plus a
// randomized character stream scored against a token-level reference model.
module tb_ascii_num_decoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_value;
    logic [2:0]  out_digits;
    logic        err;

    typedef struct {
        bit          is_err;
        logic [15:0] value;
        logic [2:0]  digits;
    } ev_t;

    int  n_checks = 0;
    int  n_fail = 0;
    int  err_seen, err_pos, ov_pos;
    ev_t obs_q[$];
    ev_t exp_q[$];

    string bnd[4] = '{"65535", "65536", "32767", "32768"};
    byte   bad_chars[6] = '{8'h61, 8'h78, 8'h2E, 8'h2D, 8'h2F, 8'h3A};
    byte   delims[4] = '{8'h20, 8'h2C, 8'h0D, 8'h0A};

    ascii_num_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_value  (out_value),
        .out_digits (out_digits),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Token-level reference: a token is everything between delimiters.
    function automatic ev_t model_token(input string t);
        ev_t    e;
        bit     neg;
        bit     bad;
        int     start;
        int     nd;
        longint mag;
        longint limit;
        neg = 1'b0;
        bad = 1'b0;
        start = 0;
        mag = 0;
`ifdef ASCII_SIGN_EN
        if (t.len() > 0 && t[0] == 8'h2D) begin
            neg = 1'b1;
            start = 1;
        end
        limit = neg ? 32768 : 32767;
`else
        limit = 65535;
`endif
        nd = t.len() - start;
        for (int j = start; j < t.len(); j++) begin
            if (t[j] >= 8'h30 && t[j] <= 8'h39) mag = mag * 10 + longint'(t[j] - 8'h30);
            else bad = 1'b1;
        end
        e.is_err = bad || (nd == 0) || (nd > 5) || (mag > limit);
        e.value  = e.is_err ? 16'd0 : (neg ? 16'(-mag) : 16'(mag));
        e.digits = e.is_err ? 3'd0 : 3'(nd);
        return e;
    endfunction

    task automatic clear_obs();
        err_seen = 0;
        err_pos = -1;
        ov_pos = -1;
        obs_q.delete();
    endtask

    task automatic sample(input int idx);
        ev_t o;
        if (err === 1'b1) begin
            err_seen++;
            err_pos = idx - 1;
        end
        if (out_valid === 1'b1 && ov_pos < 0) ov_pos = idx;
        if (out_valid === 1'b1 && out_ready) begin
            o.is_err = 1'b0;
            o.value  = out_value;
            o.digits = out_digits;
            obs_q.push_back(o);
        end
    endtask

    task automatic send_str(input string s);
        int guard;
        for (int i = 0; i < s.len(); i++) begin
            guard = 0;
            @(negedge clk);
            sample(i);
            in_valid = 1'b1;
            in_data  = s[i];
            while (in_ready !== 1'b1 && guard < 100) begin
                @(negedge clk);
                sample(i);
                guard++;
            end
            if (guard >= 100) check("in_ready_timeout", 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        sample(s.len());
        in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            sample(s.len() + 1);
        end
    endtask

    task automatic expect_out(input string tag, input int v, input int d);
        ev_t o;
        check({tag, "_count"}, 32'(obs_q.size()), 32'd1);
        if (obs_q.size() > 0) begin
            o = obs_q.pop_front();
            check({tag, "_value"}, 32'(o.value), 32'(v));
            check({tag, "_digits"}, 32'(o.digits), 32'(d));
        end
    endtask

    initial begin
        byte   stream[$];
        string tok;
        ev_t   e;
        int    cyc;
        int    drain;
        int    p;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_value", 32'(out_value), 32'd0);
        check("rst_out_digits", 32'(out_digits), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // "123 " with latency 1 after the space
        clear_obs();
        send_str("123 ");
        check("t123_latency", 32'(ov_pos), 32'd4);
        check("t123_err", 32'(err_seen), 32'd0);
        expect_out("t123", 123, 3);

`ifndef ASCII_SIGN_EN
        clear_obs();
        send_str("65535,");
        check("t65535_err", 32'(err_seen), 32'd0);
        expect_out("t65535", 65535, 5);
        clear_obs();
        send_str("65536,");
        check("t65536_err", 32'(err_seen), 32'd1);
        check("t65536_err_pos", 32'(err_pos), 32'd4);
        check("t65536_no_out", 32'(obs_q.size()), 32'd0);
        check("t65536_no_valid", 32'(ov_pos), 32'hFFFF_FFFF);
`endif

        // Malformed token is skipped up to the next delimiter
        clear_obs();
        send_str("1a2 7\r");
        check("t1a2_err", 32'(err_seen), 32'd1);
        check("t1a2_err_pos", 32'(err_pos), 32'd1);
        expect_out("t1a2_7", 7, 1);

        // Backpressure while holding 42; '9' waits on the input
        clear_obs();
        out_ready = 1'b0;
        send_str("42 ");
        in_valid = 1'b1;
        in_data  = 8'h39;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_value", 32'(out_value), 32'd42);
            check("hold_digits", 32'(out_digits), 32'd2);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        clear_obs();
        send_str(" ");
        expect_out("t9", 9, 1);

        // Reset in the middle of a token
        clear_obs();
        send_str("12");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_value", 32'(out_value), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("midrst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("postrst_valid", 32'(out_valid), 32'd0);
        check("postrst_err", 32'(err), 32'd0);
        clear_obs();
        send_str("5 ");
        check("t5_err", 32'(err_seen), 32'd0);
        expect_out("t5", 5, 1);

`ifdef ASCII_SIGN_EN
        clear_obs();
        send_str("-32768 ");
        check("neg_min_err", 32'(err_seen), 32'd0);
        expect_out("neg_min", 32'h8000, 5);
        clear_obs();
        send_str("-32769 ");
        check("neg_ovf_err", 32'(err_seen), 32'd1);
        check("neg_ovf_err_pos", 32'(err_pos), 32'd5);
        check("neg_ovf_no_out", 32'(obs_q.size()), 32'd0);
        clear_obs();
        send_str("- ");
        check("bare_minus_err", 32'(err_seen), 32'd1);
        check("bare_minus_no_out", 32'(obs_q.size()), 32'd0);
        clear_obs();
        send_str("  \n");
        check("delims_err", 32'(err_seen), 32'd0);
        check("delims_no_out", 32'(obs_q.size()), 32'd0);
        clear_obs();
        send_str("32767 ");
        expect_out("pos_max", 32767, 5);
`endif

        // Randomized stream against the token model
        stream.push_back(delims[$urandom_range(0, 3)]);
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) == 0) tok = bnd[$urandom_range(0, 3)];
            else tok = $sformatf("%0d", $urandom_range(0, 99999));
            if ($urandom_range(0, 5) == 0) tok = {"0", tok};
            if ($urandom_range(0, 4) == 0) begin
                p = $urandom_range(0, tok.len() - 1);
                tok.putc(p, bad_chars[$urandom_range(0, 5)]);
            end
`ifdef ASCII_SIGN_EN
            if ($urandom_range(0, 2) == 0) tok = {"-", tok};
            if ($urandom_range(0, 15) == 0) tok = "-";
`endif
            for (int j = 0; j < tok.len(); j++) stream.push_back(tok[j]);
            exp_q.push_back(model_token(tok));
            repeat ($urandom_range(1, 2)) stream.push_back(delims[$urandom_range(0, 3)]);
        end

        cyc = 0;
        drain = 0;
        while (cyc < 20000 && !(stream.size() == 0 && exp_q.size() == 0 && drain >= 10)) begin
            @(negedge clk);
            cyc++;
            if (err === 1'b1) begin
                if (exp_q.size() == 0) check("rand_spurious_err", 32'(err), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("rand_err_expected", 32'(err), 32'(e.is_err));
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid === 1'b1) begin
                if (exp_q.size() == 0) check("rand_spurious_out", 32'(out_valid), 32'd0);
                else begin
                    e = exp_q[0];
                    check("rand_out_expected", 32'(out_valid), 32'(!e.is_err));
                    check("rand_value", 32'(out_value), 32'(e.value));
                    check("rand_digits", 32'(out_digits), 32'(e.digits));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (stream.size() > 0 && $urandom_range(0, 4) != 0) begin
                in_valid = 1'b1;
                in_data  = stream[0];
                if (in_ready === 1'b1) void'(stream.pop_front());
            end else begin
                in_valid = 1'b0;
                in_data  = 8'($urandom_range(0, 255));
            end
            if (stream.size() == 0) drain++;
        end
        check("rand_events_left", 32'(exp_q.size()), 32'd0);
        check("rand_stream_left", 32'(stream.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
